// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset controller: sequences fetch/decode/execute/memory/writeback
// with ready/valid handshakes to instruction and data memory, plus perf counters.
module multi_cycle_control #(
    parameter  int DATA_W   = 32,
    parameter  int ALU_OP_W = 12,
    parameter  int CNT_W    = 32,
    localparam int STRB_W   = DATA_W / 8,
    localparam int AL_W     = $clog2(STRB_W)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [AL_W-1:0]     addr_lo,
    input  logic                alu_zero,
    input  logic                inst_req_ready,
    input  logic                inst_valid,
    input  logic                mem_req_ready,
    input  logic                read_data_valid,
    output logic                inst_req_valid,
    output logic                inst_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          reg_dst,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic [STRB_W-1:0]   write_strb,
    output logic                read_data_ready,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_inst,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    inst_cnt
);

    typedef enum logic [3:0] {
        S_INIT = 4'd0, S_IF = 4'd1, S_IW = 4'd2, S_ID = 4'd3, S_EX = 4'd4,
        S_ST   = 4'd5, S_LD = 4'd6, S_RDW = 4'd7, S_WB = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SB  = 6'h28, OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL = 6'h00, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25;

    state_t state_q, state_d;
    logic   inc_inst;

    logic is_r, is_addiu, is_lw, is_sb, is_sh, is_sw, is_st, is_beq, is_bne, is_j;
    logic fn_sll, fn_addu, fn_subu, fn_and, fn_or, legal, taken;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [STRB_W-1:0]   strb_b, strb_h, strb_w, st_strb;

    // Decode straight from the IR fields; they are stable from ID onward.
    always_comb begin
        is_r     = (opcode == OP_RTYPE);
        is_addiu = (opcode == OP_ADDIU);
        is_lw    = (opcode == OP_LW);
        is_sb    = (opcode == OP_SB);
        is_sh    = (opcode == OP_SH);
        is_sw    = (opcode == OP_SW);
        is_st    = is_sb | is_sh | is_sw;
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_j     = (opcode == OP_J);
        fn_sll   = is_r && (funct == FN_SLL);
        fn_addu  = is_r && (funct == FN_ADDU);
        fn_subu  = is_r && (funct == FN_SUBU);
        fn_and   = is_r && (funct == FN_AND);
        fn_or    = is_r && (funct == FN_OR);
        legal    = fn_sll | fn_addu | fn_subu | fn_and | fn_or | is_addiu | is_lw | is_st
                 | is_beq | is_bne | is_j;
        taken    = is_j | (is_beq & alu_zero) | (is_bne & ~alu_zero);

        ex_alu_op = '0;
        ex_alu_op[0] = fn_addu | is_addiu | is_lw | is_st;
        ex_alu_op[1] = fn_subu | is_beq | is_bne;
        ex_alu_op[2] = fn_and;
        ex_alu_op[3] = fn_or;
        ex_alu_op[8] = fn_sll;
    end

    // Misaligned low bits are masked off rather than trapped.
    always_comb begin
        strb_b  = STRB_W'(1)  << addr_lo;
        strb_h  = STRB_W'(3)  << (addr_lo & ~AL_W'(1));
        strb_w  = STRB_W'(15) << (addr_lo & ~AL_W'(3));
        st_strb = is_sb ? strb_b : (is_sh ? strb_h : strb_w);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        inc_inst        = 1'b0;
        inst_req_valid  = 1'b0;
        inst_ready      = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_src          = 2'b00;
        reg_dst         = 2'b00;
        alu_src         = 1'b0;
        alu_op          = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        write_strb      = '0;
        read_data_ready = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        illegal_inst    = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) state_d = S_IW;
            end
            S_IW: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (!legal) begin
                    illegal_inst = 1'b1;
                    inc_inst     = 1'b1;
                    state_d      = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_op  = ex_alu_op;
                alu_src = is_addiu | is_lw | is_st | fn_sll;
                reg_dst = is_r ? 2'b01 : 2'b00;
                if (is_beq | is_bne | is_j) begin
                    pc_write = taken;
                    pc_src   = !taken ? 2'b00 : (is_j ? 2'b10 : 2'b01);
                    inc_inst = 1'b1;
                    state_d  = S_IF;
                end else if (is_lw) begin
                    state_d = S_LD;
                end else if (is_st) begin
                    state_d = S_ST;
                end else begin
                    state_d = S_WB;
                end
            end
            S_ST: begin
                mem_write  = 1'b1;
                write_strb = st_strb;
                if (mem_req_ready) begin
                    inc_inst = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_LD: begin
                mem_read = 1'b1;
                if (mem_req_ready) state_d = S_RDW;
            end
            S_RDW: begin
                read_data_ready = 1'b1;
                if (read_data_valid) state_d = S_WB;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                reg_dst    = is_r ? 2'b01 : 2'b00;
                inc_inst   = 1'b1;
                state_d    = S_IF;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (inc_inst) inst_cnt <= inst_cnt + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: 32- and 64-bit instances run in lockstep on shared inputs
// and are compared cycle by cycle against a phase-list model built from the instruction rules.
module tb_multi_cycle_control;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] opcode, funct;
    logic [2:0] addr3;
    logic alu_zero, inst_req_ready, inst_valid, mem_req_ready, read_data_valid;

    logic        irv_a, ird_a, irw_a, pcw_a, als_a, mrd_a, mwr_a, rdr_a, m2r_a, rgw_a, ill_a;
    logic [1:0]  pcs_a, rdst_a;
    logic [11:0] aop_a;
    logic [3:0]  strb_a, state_a;
    logic [31:0] cyc_a, icnt_a;

    logic        irv_b, ird_b, irw_b, pcw_b, als_b, mrd_b, mwr_b, rdr_b, m2r_b, rgw_b, ill_b;
    logic [1:0]  pcs_b, rdst_b;
    logic [11:0] aop_b;
    logic [7:0]  strb_b;
    logic [3:0]  state_b;
    logic [31:0] cyc_b, icnt_b;

    multi_cycle_control #(.DATA_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .addr_lo(addr3[1:0]),
        .alu_zero(alu_zero), .inst_req_ready(inst_req_ready), .inst_valid(inst_valid),
        .mem_req_ready(mem_req_ready), .read_data_valid(read_data_valid),
        .inst_req_valid(irv_a), .inst_ready(ird_a), .ir_write(irw_a), .pc_write(pcw_a),
        .pc_src(pcs_a), .reg_dst(rdst_a), .alu_src(als_a), .alu_op(aop_a), .mem_read(mrd_a),
        .mem_write(mwr_a), .write_strb(strb_a), .read_data_ready(rdr_a), .mem_to_reg(m2r_a),
        .reg_write(rgw_a), .illegal_inst(ill_a), .state(state_a), .cycle_cnt(cyc_a),
        .inst_cnt(icnt_a));

    multi_cycle_control #(.DATA_W(64)) dut_b (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .addr_lo(addr3),
        .alu_zero(alu_zero), .inst_req_ready(inst_req_ready), .inst_valid(inst_valid),
        .mem_req_ready(mem_req_ready), .read_data_valid(read_data_valid),
        .inst_req_valid(irv_b), .inst_ready(ird_b), .ir_write(irw_b), .pc_write(pcw_b),
        .pc_src(pcs_b), .reg_dst(rdst_b), .alu_src(als_b), .alu_op(aop_b), .mem_read(mrd_b),
        .mem_write(mwr_b), .write_strb(strb_b), .read_data_ready(rdr_b), .mem_to_reg(m2r_b),
        .reg_write(rgw_b), .illegal_inst(ill_b), .state(state_b), .cycle_cnt(cyc_b),
        .inst_cnt(icnt_b));

    wire [34:0] outs_a = {irv_a, ird_a, irw_a, pcw_a, pcs_a, rdst_a, als_a, aop_a, mrd_a, mwr_a,
                          strb_a, rdr_a, m2r_a, rgw_a, ill_a, state_a};
    wire [38:0] outs_b = {irv_b, ird_b, irw_b, pcw_b, pcs_b, rdst_b, als_b, aop_b, mrd_b, mwr_b,
                          strb_b, rdr_b, m2r_b, rgw_b, ill_b, state_b};
    wire [8:0] hs_a = {irv_a, ird_a, irw_a, pcw_a, mrd_a, mwr_a, rdr_a, rgw_a, ill_a};
    wire [8:0] hs_b = {irv_b, ird_b, irw_b, pcw_b, mrd_b, mwr_b, rdr_b, rgw_b, ill_b};

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_cyc;
    logic [31:0] exp_inst = 0;

    // Cycles since reset release, straight from the counter definition.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) exp_cyc <= 0;
        else         exp_cyc <= exp_cyc + 1;
    end

    // Builds the expected phase sequence for one instruction from the ISA rules, drives the
    // handshakes (ready/valid arriving on the last cycle of each phase) and checks every cycle.
    // Must be entered at posedge+1 with both DUTs in IF.
    task automatic run_inst(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic [2:0] ad, input int wif, input int wiw, input int wm,
                            input int wr);
        int ph[$];
        bit lst[$];
        bit r, rok, addiu, lw, sb, sh, sw, st, beq, bne, jj, ill, taken;
        logic [11:0] e_alu;
        logic [8:0]  e_hs;
        logic [3:0]  e_s32, x_s32;
        logic [7:0]  e_s64, x_s64;
        logic [1:0]  e_dst, e_pcs;
        int nb, p;
        bit l, e_src;
        r = (op == 6'h00);
        rok = r && (fn == 6'h00 || fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25);
        addiu = (op == 6'h09); lw = (op == 6'h23);
        sb = (op == 6'h28); sh = (op == 6'h29); sw = (op == 6'h2b); st = sb | sh | sw;
        beq = (op == 6'h04); bne = (op == 6'h05); jj = (op == 6'h02);
        ill = !(rok | addiu | lw | st | beq | bne | jj);
        taken = jj | (beq & z) | (bne & !z);

        for (int i = 0; i <= wif; i++) begin ph.push_back(1); lst.push_back(i == wif); end
        for (int i = 0; i <= wiw; i++) begin ph.push_back(2); lst.push_back(i == wiw); end
        ph.push_back(3); lst.push_back(1'b1);
        if (!ill) begin
            ph.push_back(4); lst.push_back(1'b1);
            if (st) for (int i = 0; i <= wm; i++) begin ph.push_back(5); lst.push_back(i == wm); end
            if (lw) begin
                for (int i = 0; i <= wm; i++) begin ph.push_back(6); lst.push_back(i == wm); end
                for (int i = 0; i <= wr; i++) begin ph.push_back(7); lst.push_back(i == wr); end
            end
            if (lw || rok || addiu) begin ph.push_back(8); lst.push_back(1'b1); end
        end

        if (addiu || lw || st || (r && fn == 6'h21)) e_alu = 12'h001;
        else if (beq || bne || (r && fn == 6'h23))   e_alu = 12'h002;
        else if (r && fn == 6'h24)                    e_alu = 12'h004;
        else if (r && fn == 6'h25)                    e_alu = 12'h008;
        else if (r && fn == 6'h00)                    e_alu = 12'h100;
        else                                          e_alu = 12'h000;
        e_src = addiu | lw | st | (r && fn == 6'h00);
        e_dst = r ? 2'b01 : 2'b00;
        nb = sb ? 1 : (sh ? 2 : 4);
        e_s32 = 4'(((1 << nb) - 1) << ((int'(ad) % 4) / nb * nb));
        e_s64 = 8'(((1 << nb) - 1) << ((int'(ad) % 8) / nb * nb));

        for (int k = 0; k < ph.size(); k++) begin
            p = ph[k];
            l = lst[k];
            opcode          = (p < 3) ? 6'($urandom) : op;
            funct           = (p < 3) ? 6'($urandom) : fn;
            alu_zero        = z;
            addr3           = ad;
            inst_req_ready  = (p == 1) ? l : 1'($urandom);
            inst_valid      = (p == 2) ? l : 1'($urandom);
            mem_req_ready   = (p == 5 || p == 6) ? l : 1'($urandom);
            read_data_valid = (p == 7) ? l : 1'($urandom);
            @(negedge clk);
            e_hs = {p == 1, p == 2, p == 2 && l, (p == 2 && l) || (p == 4 && taken),
                    p == 6, p == 5, p == 7, p == 8, p == 3 && ill};
            n_total++;
            if (state_a !== 4'(p) || state_b !== 4'(p) || hs_a !== e_hs || hs_b !== e_hs)
                $display("FAIL seq op=%h fn=%h cyc=%0d: state %0d/%0d ctl %b/%b, required state %0d ctl %b",
                         op, fn, k, state_a, state_b, hs_a, hs_b, p, e_hs);
            else n_pass++;
            x_s32 = (p == 5) ? e_s32 : 4'h0;
            x_s64 = (p == 5) ? e_s64 : 8'h00;
            n_total++;
            if (strb_a !== x_s32 || strb_b !== x_s64)
                $display("FAIL write_strb op=%h ad=%0d cyc=%0d: %h/%h, required %h/%h",
                         op, ad, k, strb_a, strb_b, x_s32, x_s64);
            else n_pass++;
            if (e_hs[5]) begin
                e_pcs = (p == 2) ? 2'b00 : (jj ? 2'b10 : 2'b01);
                n_total++;
                if (pcs_a !== e_pcs || pcs_b !== e_pcs)
                    $display("FAIL pc_src op=%h: %b/%b, required %b", op, pcs_a, pcs_b, e_pcs);
                else n_pass++;
            end
            if (p == 4) begin
                n_total++;
                if (aop_a !== e_alu || aop_b !== e_alu || als_a !== e_src || rdst_a !== e_dst)
                    $display("FAIL ex_ctl op=%h fn=%h: alu_op %h src %b dst %b, required %h %b %b",
                             op, fn, aop_a, als_a, rdst_a, e_alu, e_src, e_dst);
                else n_pass++;
            end
            if (p == 8) begin
                n_total++;
                if (rdst_a !== e_dst || m2r_a !== lw || m2r_b !== lw)
                    $display("FAIL wb_ctl op=%h: reg_dst %b mem_to_reg %b, required %b %b",
                             op, rdst_a, m2r_a, e_dst, lw);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        exp_inst = exp_inst + 1;
        n_total++;
        if (icnt_a !== exp_inst || icnt_b !== exp_inst || cyc_a !== exp_cyc || state_a !== 4'd1)
            $display("FAIL counters op=%h: inst_cnt %0d cycle_cnt %0d state %0d, required %0d %0d 1",
                     op, icnt_a, cyc_a, state_a, exp_inst, exp_cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        exp_inst = 0;
        for (int i = 0; i < 3; i++) begin
            opcode = 6'($urandom); funct = 6'($urandom); addr3 = 3'($urandom);
            alu_zero = 1'($urandom); inst_req_ready = 1'($urandom); inst_valid = 1'($urandom);
            mem_req_ready = 1'($urandom); read_data_valid = 1'($urandom);
            @(negedge clk);
            n_total++;
            if (outs_a !== '0 || outs_b !== '0 || cyc_a !== 0 || icnt_a !== 0 || cyc_b !== 0)
                $display("FAIL reset_outputs: %h/%h cyc %0d inst %0d, required all zero",
                         outs_a, outs_b, cyc_a, icnt_a);
            else n_pass++;
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        inst_req_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (state_a !== 4'd0 || cyc_a !== 0)
            $display("FAIL reset_init: state %0d cycle_cnt %0d, required 0 0", state_a, cyc_a);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (state_a !== 4'd1 || state_b !== 4'd1 || cyc_a !== 1)
            $display("FAIL init_to_if: state %0d cycle_cnt %0d, required 1 1", state_a, cyc_a);
        else n_pass++;
    endtask

    task automatic test_addiu();
        run_inst(6'h09, 6'($urandom), 1'b0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic test_rtype();
        run_inst(6'h00, 6'h21, 1'b0, 3'd0, 1, 0, 0, 0);
        run_inst(6'h00, 6'h23, 1'b1, 3'd0, 0, 2, 0, 0);
        run_inst(6'h00, 6'h24, 1'b0, 3'd0, 0, 0, 0, 0);
        run_inst(6'h00, 6'h25, 1'b0, 3'd0, 2, 1, 0, 0);
        run_inst(6'h00, 6'h00, 1'b0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        run_inst(6'h05, 6'($urandom), 1'b0, 3'd0, 0, 0, 0, 0);
        run_inst(6'h05, 6'($urandom), 1'b1, 3'd0, 0, 0, 0, 0);
        run_inst(6'h04, 6'($urandom), 1'b1, 3'd0, 0, 0, 0, 0);
        run_inst(6'h04, 6'($urandom), 1'b0, 3'd0, 0, 0, 0, 0);
        run_inst(6'h02, 6'($urandom), 1'b1, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic test_store();
        run_inst(6'h28, 6'($urandom), 1'b0, 3'b010, 0, 0, 3, 0);
        run_inst(6'h29, 6'($urandom), 1'b0, 3'b010, 0, 0, 0, 0);
        run_inst(6'h2b, 6'($urandom), 1'b0, 3'b011, 0, 0, 1, 0);
        run_inst(6'h28, 6'($urandom), 1'b0, 3'b101, 0, 0, 0, 0);
        run_inst(6'h29, 6'($urandom), 1'b0, 3'b111, 0, 0, 0, 0);
        run_inst(6'h2b, 6'($urandom), 1'b0, 3'b110, 0, 0, 2, 0);
    endtask

    task automatic test_load();
        run_inst(6'h23, 6'($urandom), 1'b0, 3'd0, 0, 0, 0, 2);
        run_inst(6'h23, 6'($urandom), 1'b1, 3'd4, 1, 1, 2, 0);
    endtask

    task automatic test_illegal();
        run_inst(6'h3f, 6'($urandom), 1'b0, 3'd0, 0, 0, 0, 0);
        run_inst(6'h00, 6'h20, 1'b0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        int k;
        opcode = 6'h23; funct = 6'h00; addr3 = 3'd0; alu_zero = 1'b0;
        inst_req_ready = 1'b1; inst_valid = 1'b1; mem_req_ready = 1'b0; read_data_valid = 1'b0;
        k = 0;
        while (state_a !== 4'd6 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(negedge clk);
        n_total++;
        if (state_a !== 4'd6 || mrd_a !== 1'b1 || mrd_b !== 1'b1)
            $display("FAIL reach_ld: state %0d mem_read %b, required 6 1", state_a, mrd_a);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        exp_inst = 0;
        n_total++;
        if (outs_a !== '0 || outs_b !== '0 || cyc_a !== 0 || icnt_a !== 0 || icnt_b !== 0)
            $display("FAIL reset_mid: %h/%h cyc %0d inst %0d, required all zero",
                     outs_a, outs_b, cyc_a, icnt_a);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (state_a !== 4'd1 || cyc_a !== exp_cyc || cyc_a !== 1)
            $display("FAIL restart: state %0d cycle_cnt %0d, required 1 1", state_a, cyc_a);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops[12];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h00, 6'h09, 6'h23, 6'h28, 6'h29, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f, 6'h0f};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2a};
        for (int i = 0; i < 60; i++)
            run_inst(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 5)], 1'($urandom),
                     3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_rtype();
        test_branch();
        test_store();
        test_load();
        test_illegal();
        test_random();
        test_reset_mid();
        test_addiu();
        test_store();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, handshaking with the instruction and data memory ports.
- Decodes an extended MIPS subset: R-type ADDU/SUBU/AND/OR/SLL, ADDIU, LW, SW, SH, SB, BEQ, BNE, J.
- Generates byte-lane write strobes from the low address bits and keeps cycle and retired-instruction counters.

Parameters:
DATA_W, 32, datapath width; legal values are 32 and 64 only. STRB_W = DATA_W/8; AL_W = log2(STRB_W).
ALU_OP_W, 12, one-hot ALU op width; must be >= 12.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  asynchronous, active-low reset.
opcode  in  6  IR[31:26], valid from ID onward.
funct  in  6  IR[5:0].
addr_lo  in  AL_W  low bits of the ALU result (effective address), valid in ST.
alu_zero  in  1  ALU zero flag, valid in EX.
inst_req_ready  in  1  instruction memory accepts the address.
inst_valid  in  1  instruction word is present.
mem_req_ready  in  1  data memory accepts a read or write request.
read_data_valid  in  1  load data is present.
inst_req_valid  out  1  fetch request.
inst_ready  out  1  ready to accept the instruction word.
ir_write  out  1  latch IR.
pc_write  out  1  update PC.
pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
reg_dst  out  2  00 = rt, 01 = rd.
alu_src  out  1  1 = immediate/shamt operand.
alu_op  out  ALU_OP_W  one-hot: 0 ADD, 1 SUB, 2 AND, 3 OR, 8 SLL; other bits 0.
mem_read  out  1  load request.
mem_write  out  1  store request.
write_strb  out  STRB_W  byte enables.
read_data_ready  out  1  ready to accept load data.
mem_to_reg  out  1  writeback source is memory.
reg_write  out  1  register file write enable.
illegal_inst  out  1  one-cycle pulse on an unsupported opcode/funct.
state  out  4  current state encoding, for debug.
cycle_cnt  out  CNT_W  cycles since reset deassertion.
inst_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset: resetn low asynchronously forces state INIT(0); cycle_cnt and inst_cnt clear to 0.
  - All outputs are combinational from state and inputs (Moore/Mealy), so every control output is 0 during reset.
  - Reset asserted mid-operation aborts any outstanding handshake immediately; no pc_write or reg_write is issued.
- State encoding: INIT=0, IF=1, IW=2, ID=3, EX=4, ST=5, LD=6, RDW=7, WB=8.
- INIT -> IF unconditionally after the first clock with resetn high.
- IF:
  - inst_req_valid = 1.
  - Moves to IW on inst_req_ready; otherwise holds.
- IW:
  - inst_ready = 1.
  - On inst_valid: ir_write = 1, pc_write = 1, pc_src = 00, then -> ID.
- ID: decode only. Unsupported instruction -> illegal_inst pulse, inst_cnt += 1, -> IF. Otherwise -> EX.
- EX:
  - Control outputs:
    - alu_op: ADD for ADDU/ADDIU/loads/stores; SUB for BEQ/BNE; per funct for the other R-types.
    - alu_src = 1 for ADDIU, loads, stores and SLL.
    - reg_dst = 01 for R-type, 00 otherwise.
  - Branches: BEQ and alu_zero, or BNE and !alu_zero -> pc_write = 1, pc_src = 01. Branch then -> IF with inst_cnt += 1.
  - J: pc_write = 1, pc_src = 10; -> IF with inst_cnt += 1.
  - Next state:
    - LW -> LD.
    - SW/SH/SB -> ST.
    - R-type/ADDIU -> WB.
- ST:
  - mem_write = 1, held until mem_req_ready; then inst_cnt += 1 and -> IF.
  - write_strb:
    - SB: 1 << addr_lo.
    - SH: 2'b11 << {addr_lo[AL_W-1:1], 0}.
    - SW: 4'b1111 << {addr_lo[AL_W-1:2], 00}.
    - All shifts are zero-extended to STRB_W.
  - write_strb = 0 in every other state.
  - Misaligned halfword/word bits are ignored; there is no exception.
- LD: mem_read = 1, held until mem_req_ready; then -> RDW.
- RDW: read_data_ready = 1 until read_data_valid; then -> WB.
- WB:
  - reg_write = 1 for exactly one cycle.
  - mem_to_reg = 1 for LW.
  - reg_dst as in EX.
  - inst_cnt += 1, then -> IF.
- Request signals stay asserted and stable until their ready/valid arrives; there is no timeout.
- Simultaneous valid/ready in the first cycle of a state completes that handshake in one cycle.
- Counters:
  - cycle_cnt increments every cycle while not in reset and wraps modulo 2^CNT_W.
  - inst_cnt also wraps modulo 2^CNT_W.

Test Plan:
- ADDIU with inst_req_ready and inst_valid both high immediately -> states 1,2,3,4,8,1; reg_write high 1 cycle; reg_dst = 00; alu_op = 12'h001; inst_cnt = 1.
- BNE with alu_zero = 0 -> in EX pc_write = 1, pc_src = 01, alu_op = 12'h002; returns to IF after 4 cycles. Repeat with alu_zero = 1 -> no pc_write in EX.
- SB at addr_lo = 2'b10 (DATA_W=32), mem_req_ready delayed 3 cycles -> write_strb = 4'b0100 and mem_write stable for 4 cycles. SH at addr_lo = 2'b10 -> 4'b1100. SW -> 4'b1111.
- LW with read_data_valid delayed 2 cycles -> RDW held; WB has mem_to_reg = 1, reg_write = 1, reg_dst = 00.
- Opcode 6'b111111 -> illegal_inst pulse in ID, no reg_write/mem_write/pc_write beyond fetch; next state is IF.
- resetn low during LD with mem_read high -> same-cycle drop to state 0, all outputs 0, counters 0. DATA_W=64 SB at addr_lo = 3'b101 -> write_strb = 8'h20.
